// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Word-aligned PC generation, one-outstanding imem read, prefetch
//             FIFO toward decode, redirect flush.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_addr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]      last_instr_q, last_pc_q;
    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];

    logic w_push, w_pop, w_issue;
    logic w_unused_ok;

    assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

    assign instr_valid = (count_q != '0);
    assign w_push      = (state_q == S_WAIT) && imem_ack && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign w_issue     = (state_q == S_IDLE) && !redirect_valid && (count_q < FULL_CNT);

    // Empty FIFO shows the most recent head rather than a stale slot
    assign instr    = instr_valid ? mem_instr[rd_ptr_q] : last_instr_q;
    assign instr_pc = instr_valid ? mem_pc[rd_ptr_q]    : last_pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_issue) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack)            state_d = S_IDLE;
                else if (redirect_valid) state_d = S_DROP;
            end
            S_DROP:  if (imem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address is frozen in req_addr_q so a redirect during DROP cannot disturb it
    always_comb begin
        imem_req  = (state_q != S_IDLE);
        imem_addr = (state_q == S_IDLE) ? fetch_pc_q : req_addr_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= RESET_PC;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (w_issue) begin
                req_addr_q <= fetch_pc_q;
            end
            if (instr_valid) begin
                last_instr_q <= mem_instr[rd_ptr_q];
                last_pc_q    <= mem_pc[rd_ptr_q];
            end
            if (redirect_valid) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_instr[wr_ptr_q] <= imem_rdata;
            mem_pc[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule

`default_nettype wire
